csi2_vc_demux_1to4: RTL

Byte-domain CSI-2 virtual-channel demultiplexer: the receive-side counterpart of the 4-to-1 camera lane mux. It takes the merged 2-lane HS word stream from the D-PHY receiver, parses each packet header, and routes the whole packet to one of four per-virtual-channel outputs. It also tracks per-VC frame state and counts dropped packets. It sits between the D-PHY RX word aligner and the four per-camera pixel unpackers.

---
 rtl/csi2_vc_demux_1to4.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/csi2_vc_demux_1to4.sv
// CSI-2 virtual-channel demultiplexer: parses the merged HS word stream and routes whole packets
// to one of four per-VC outputs through a 2-stage delay line. Header ECC check: CSI2_VC_DEMUX_ECC_EN.
module csi2_vc_demux_1to4 #(
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  input  logic                  sot_i,
  input  logic [15:0]           data_i,
  input  logic [3:0]            ch_en_i,
  output logic [3:0]            out_valid_o,
  output logic [15:0]           data_o,
  output logic [1:0]            be_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic [5:0]            dt_o,
  output logic [15:0]           wc_o,
  output logic                  abort_o,
  output logic [3:0]            in_frame_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR1 = 2'd1,
    ST_BODY = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [16:0] rem_r, rem_s;
  logic        odd_r, odd_s;
  logic [3:0]  oh_r, oh_s;
  logic [15:0] s1_data_r;
  logic        s1_fwd_r, s1_fwd_s;
  logic        s1_eop_r, s1_eop_s;
  logic [1:0]  s1_be_r, s1_be_s;
  logic        s1_abort_r, s1_abort_s;
  logic        hdr_take_s;
  logic        drop_inc_s;
  logic [3:0]  frame_s;

  // Header word 0 sits in stage 1 while word 1 is on the input.
  logic [1:0]  hdr_vc_s;
  logic [5:0]  hdr_dt_s;
  logic [15:0] hdr_wc_s;
  logic        hdr_short_s;
  logic [16:0] body_sum_s;
  logic [16:0] body_cnt_s;
  logic        ecc_ok_s;
  logic        hdr_keep_s;

  assign hdr_vc_s    = s1_data_r[7:6];
  assign hdr_dt_s    = s1_data_r[5:0];
  assign hdr_wc_s    = {data_i[7:0], s1_data_r[15:8]};
  assign hdr_short_s = (hdr_dt_s <= 6'h0F);
  assign body_sum_s  = {1'b0, hdr_wc_s} + 17'd3;
  assign body_cnt_s  = {1'b0, body_sum_s[16:1]};

`ifdef CSI2_VC_DEMUX_ECC_EN
  function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  assign ecc_ok_s = (data_i[15:14] == 2'b00) &&
                    (data_i[13:8] == csi2_ecc({data_i[7:0], s1_data_r}));
`else
  assign ecc_ok_s = 1'b1;
`endif

  assign hdr_keep_s = ch_en_i[hdr_vc_s] && ecc_ok_s;

  // Packet parser: next state, stage-1 tags, drop and frame decisions.
  always_comb begin
    state_s    = state_r;
    rem_s      = rem_r;
    odd_s      = odd_r;
    oh_s       = oh_r;
    s1_fwd_s   = 1'b0;
    s1_eop_s   = 1'b0;
    s1_be_s    = 2'b11;
    s1_abort_s = 1'b0;
    hdr_take_s = 1'b0;
    drop_inc_s = 1'b0;
    frame_s    = in_frame_o;
    case (state_r)
      ST_IDLE: begin
        if (valid_i) begin
          state_s = ST_HDR1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR1: begin
        if (valid_i && sot_i) begin
          s1_abort_s = 1'b1;
          state_s    = ST_HDR1;
        end else if (valid_i) begin
          rem_s = body_cnt_s;
          odd_s = hdr_wc_s[0];
          oh_s  = 4'b0001 << hdr_vc_s;
          if (hdr_keep_s) begin
            hdr_take_s = 1'b1;
            s1_fwd_s   = 1'b1;
            s1_eop_s   = hdr_short_s;
            state_s    = hdr_short_s ? ST_IDLE : ST_BODY;
            if (hdr_dt_s == 6'h00) begin
              frame_s[hdr_vc_s] = 1'b1;
            end else if (hdr_dt_s == 6'h01) begin
              frame_s[hdr_vc_s] = 1'b0;
            end else begin
              frame_s = in_frame_o;
            end
          end else begin
            drop_inc_s = 1'b1;
            state_s    = hdr_short_s ? ST_IDLE : ST_DROP;
          end
        end else begin
          // Header gap: the packet cannot be routed.
          drop_inc_s = 1'b1;
          state_s    = ST_IDLE;
        end
      end
      ST_BODY, ST_DROP: begin
        if (valid_i && sot_i) begin
          s1_abort_s = 1'b1;
          state_s    = ST_HDR1;
        end else if (valid_i) begin
          s1_fwd_s = (state_r == ST_BODY);
          rem_s    = rem_r - 17'd1;
          if (rem_r == 17'd1) begin
            s1_eop_s = 1'b1;
            s1_be_s  = odd_r ? 2'b01 : 2'b11;
            state_s  = ST_IDLE;
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Parser state, frame flags and drop counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= ST_IDLE;
      rem_r      <= 17'd0;
      odd_r      <= 1'b0;
      oh_r       <= 4'b0000;
      in_frame_o <= 4'b0000;
      drop_cnt_o <= {DROP_CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      rem_r      <= rem_s;
      odd_r      <= odd_s;
      oh_r       <= oh_s;
      in_frame_o <= frame_s;
      if (drop_inc_s && (drop_cnt_o != {DROP_CNT_W{1'b1}})) begin
        drop_cnt_o <= drop_cnt_o + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        drop_cnt_o <= drop_cnt_o;
      end
    end
  end

  // Two-stage delay line; word 0 is released from stage 1 once the header is accepted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_data_r   <= 16'h0000;
      s1_fwd_r    <= 1'b0;
      s1_eop_r    <= 1'b0;
      s1_be_r     <= 2'b00;
      s1_abort_r  <= 1'b0;
      out_valid_o <= 4'b0000;
      data_o      <= 16'h0000;
      be_o        <= 2'b00;
      sop_o       <= 1'b0;
      eop_o       <= 1'b0;
      dt_o        <= 6'h00;
      wc_o        <= 16'h0000;
      abort_o     <= 1'b0;
    end else begin
      s1_data_r   <= data_i;
      s1_fwd_r    <= s1_fwd_s;
      s1_eop_r    <= s1_eop_s;
      s1_be_r     <= s1_be_s;
      s1_abort_r  <= s1_abort_s;
      out_valid_o <= hdr_take_s ? oh_s : (s1_fwd_r ? oh_r : 4'b0000);
      data_o      <= s1_data_r;
      be_o        <= s1_fwd_r ? s1_be_r : (hdr_take_s ? 2'b11 : 2'b00);
      sop_o       <= hdr_take_s;
      eop_o       <= s1_fwd_r & s1_eop_r;
      abort_o     <= s1_abort_r;
      if (hdr_take_s) begin
        dt_o <= hdr_dt_s;
        wc_o <= hdr_wc_s;
      end else begin
        dt_o <= dt_o;
        wc_o <= wc_o;
      end
    end
  end

endmodule
